// File: rtl/dp_dmi_ctrl.sv
// DMI request controller: runs one debug-module bus access per DMI Update-DR and
// builds the Capture-DR word. Define DP_DMI_TIMEOUT_EN to add a bus-timeout counter.
module dp_dmi_ctrl #(
    parameter int ABITS      = 7,
    parameter int TMO_CYCLES = 255
) (
    input  logic              iclk,
    input  logic              iresetn,
    input  logic              upd_dmi,
    input  logic              cap_dmi,
    input  logic [ABITS+33:0] dmi_pdi,
    output logic [ABITS+33:0] dmi_pdo,
    input  logic              dmireset,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ABITS-1:0]  dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_err,
    output logic              busy
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_FAIL = 2'd2;
    localparam logic [1:0] ST_BUSY = 2'd3;

    if (TMO_CYCLES < 1) begin : g_bad_tmo
        $error("dp_dmi_ctrl: TMO_CYCLES must be at least 1");
    end

    state_e            state_q;
    logic              req_q;
    logic              we_q;
    logic [ABITS-1:0]  addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic [1:0]        sticky_q;
    logic [1:0]        status_d;
    logic [ABITS+33:0] pdo_q;

    logic [1:0] op;
    logic       in_req;
    logic       complete;
    logic       expire;
    logic       accept;

    assign in_req = (state_q == REQ);

`ifdef DP_DMI_TIMEOUT_EN
    localparam int CW = ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q;
    // cnt_q holds the REQ cycles already finished, so this edge closes cycle cnt_q+1.
    assign expire = in_req && !dm_ack && (cnt_q == CW'(TMO_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    // status_d is the pre-clear status of this edge; dmireset is applied only to the sticky register.
    always_comb begin
        op       = dmi_pdi[1:0];
        complete = in_req && dm_ack;
        accept   = !in_req && upd_dmi && (op == 2'd1 || op == 2'd2)
                   && (dmireset || sticky_q == ST_OK);
        rdata_d  = (complete && !we_q) ? dm_rdata : rdata_q;
        status_d = sticky_q;
        if (sticky_q == ST_OK && ((complete && dm_err) || expire)) begin
            status_d = ST_FAIL;
        end
        if (in_req && !complete && !expire && (upd_dmi || cap_dmi)) begin
            status_d = ST_BUSY;
        end
    end

    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sticky_q <= ST_OK;
            pdo_q    <= '0;
`ifdef DP_DMI_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            rdata_q  <= rdata_d;
            sticky_q <= dmireset ? ST_OK : status_d;
            if (cap_dmi) begin
                pdo_q <= {addr_q, rdata_d, status_d};
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= (op == 2'd2);
                        addr_q  <= dmi_pdi[ABITS+33:34];
                        wdata_q <= dmi_pdi[33:2];
`ifdef DP_DMI_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (complete || expire) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
`ifdef DP_DMI_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm_req   = req_q;
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign busy     = in_req;
    assign dmi_pdo  = pdo_q;

endmodule

// File: tb/tb_dp_dmi_ctrl.sv
// Bench for dp_dmi_ctrl: directed scenarios plus random DMI traffic checked against
// a transaction-level model of the DMI status/read-data/bus-request behaviour.
module tb_dp_dmi_ctrl;

    localparam int ABITS = 7;
    localparam int TMO   = 4;
    localparam int PW    = ABITS + 34;
    localparam int W     = ABITS + 33;

    logic              iclk;
    logic              iresetn;
    logic              upd_dmi;
    logic              cap_dmi;
    logic [PW-1:0]     dmi_pdi;
    logic [PW-1:0]     dmi_pdo;
    logic              dmireset;
    logic              dm_req;
    logic              dm_we;
    logic [ABITS-1:0]  dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ack;
    logic [31:0]       dm_rdata;
    logic              dm_err;
    logic              busy;

    dp_dmi_ctrl #(.ABITS(ABITS), .TMO_CYCLES(TMO)) dut (
        .iclk(iclk), .iresetn(iresetn), .upd_dmi(upd_dmi), .cap_dmi(cap_dmi),
        .dmi_pdi(dmi_pdi), .dmi_pdo(dmi_pdo), .dmireset(dmireset),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err), .busy(busy)
    );

    // clock / reset
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // reference model state: one outstanding request at most
    bit               m_busy;
    bit               m_we;
    logic [1:0]       m_sticky;
    logic [31:0]      m_rdata;
    logic [ABITS-1:0] m_addr;
    logic [31:0]      m_wdata;
    int               m_cyc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_sticky = 2'd0; m_rdata = '0;
        m_addr = '0; m_wdata = '0; m_cyc = 0;
    endtask

    // Pending request spends one more cycle without ack; returns 1 if it expires now.
    function automatic bit model_timeout();
        model_timeout = 1'b0;
`ifdef DP_DMI_TIMEOUT_EN
        if (m_busy) begin
            m_cyc++;
            if (m_cyc == TMO) begin
                m_busy = 0;
                if (m_sticky == 2'd0) m_sticky = 2'd2;
                model_timeout = 1'b1;
            end
        end
`endif
    endfunction

    // Every bus request that appears must be one the model accepted, with its attributes.
    logic prev_req = 1'b0;
    always @(negedge iclk) begin
        if (dm_req && !prev_req) begin
            if (exp_q.size() == 0) check_eq("unexpected_req", 64'd1, 64'd0);
            else check_eq("req_attr", {dm_we, dm_addr, dm_wdata}, exp_q.pop_front());
        end
        prev_req = dm_req;
    end

    // driver tasks: called just after a negedge, return just after the next negedge
    task automatic tick();
        @(posedge iclk);
        @(negedge iclk);
    endtask

    task automatic chk_state(input string tag);
        check_eq({tag, "_req"}, dm_req, m_busy);
        check_eq({tag, "_busy"}, busy, m_busy);
    endtask

    task automatic idle_step();
        void'(model_timeout());
        tick();
        chk_state("idle");
    endtask

    task automatic do_upd(input logic [1:0] op, input logic [ABITS-1:0] a,
                          input logic [31:0] d, input bit clr);
        bit was, expired;
        upd_dmi = 1'b1; dmireset = clr; dmi_pdi = {a, d, op};
        was = m_busy;
        expired = model_timeout();
        if (clr) m_sticky = 2'd0;
        if (was) begin
            if (!expired) m_sticky = 2'd3;
        end else if (m_sticky == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
            m_busy = 1; m_we = (op == 2'd2); m_addr = a; m_wdata = d; m_cyc = 0;
            exp_q.push_back({m_we, a, d});
        end
        tick();
        upd_dmi = 1'b0; dmireset = 1'b0;
        chk_state("upd");
    endtask

    task automatic do_cap(input bit clr);
        bit was, expired;
        logic [1:0] st;
        logic [PW-1:0] exp_pdo;
        cap_dmi = 1'b1; dmireset = clr;
        was = m_busy;
        expired = model_timeout();
        st = (was && !expired) ? 2'd3 : m_sticky;
        if (was && !expired) m_sticky = 2'd3;
        exp_pdo = {m_addr, m_rdata, st};
        if (clr) m_sticky = 2'd0;
        tick();
        cap_dmi = 1'b0; dmireset = 1'b0;
        check_eq("cap_pdo", dmi_pdo, exp_pdo);
        chk_state("cap");
    endtask

    task automatic do_dmireset();
        dmireset = 1'b1;
        void'(model_timeout());
        m_sticky = 2'd0;
        tick();
        dmireset = 1'b0;
        chk_state("dmireset");
    endtask

    // Hold ack low for dly cycles, then ack for one cycle (optionally with a capture).
    task automatic do_ack(input int dly, input bit err, input logic [31:0] rd, input bit cap);
        logic [PW-1:0] exp_pdo;
        for (int i = 0; i < dly; i++) begin
            if (!m_busy) return;
            check_eq("wait_attr", {dm_req, dm_we, dm_addr, dm_wdata}, {1'b1, m_we, m_addr, m_wdata});
            void'(model_timeout());
            tick();
            chk_state("wait");
        end
        if (!m_busy) return;
        check_eq("ack_attr", {dm_req, dm_we, dm_addr, dm_wdata}, {1'b1, m_we, m_addr, m_wdata});
        dm_ack = 1'b1; dm_err = err; dm_rdata = rd; cap_dmi = cap;
        m_busy = 0;
        if (!m_we) m_rdata = rd;
        if (err && m_sticky == 2'd0) m_sticky = 2'd2;
        exp_pdo = {m_addr, m_rdata, m_sticky};
        tick();
        dm_ack = 1'b0; dm_err = 1'b0; cap_dmi = 1'b0; dm_rdata = $urandom;
        chk_state("ack");
        if (cap) check_eq("ack_cap_pdo", dmi_pdo, exp_pdo);
    endtask

    int         act;
    logic [1:0] r_op;
    logic [6:0] r_a;
    bit         r_clr;
    int         hi_cnt;

    initial begin
        iresetn = 1'b0; upd_dmi = 1'b0; cap_dmi = 1'b0; dmireset = 1'b0;
        dmi_pdi = '0; dm_ack = 1'b0; dm_err = 1'b0; dm_rdata = $urandom;
        model_reset();
        repeat (3) @(negedge iclk);
        check_eq("rst_req", dm_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_we", dm_we, 0);
        check_eq("rst_addr", dm_addr, 0);
        check_eq("rst_wdata", dm_wdata, 0);
        check_eq("rst_pdo", dmi_pdo, 0);
        iresetn = 1'b1;
        idle_step();
        do_cap(0);

        // write: 3 cycles of dm_req, then status 0
        do_upd(2'd2, 7'h10, 32'hDEADBEEF, 0);
        check_eq("plan_wr_attr", {dm_req, dm_we, dm_addr, dm_wdata}, {1'b1, 1'b1, 7'h10, 32'hDEADBEEF});
        do_ack(2, 0, $urandom, 0);
        do_cap(0);

        // read
        do_upd(2'd1, 7'h11, 32'h0, 0);
        do_ack(0, 0, 32'h12345678, 0);
        do_cap(0);
        check_eq("plan_rd_pdo", dmi_pdo, {7'h11, 32'h12345678, 2'd0});

        // nop and reserved opcodes
        do_upd(2'd0, 7'h22, $urandom, 0);
        do_upd(2'd3, 7'h23, $urandom, 0);

        // busy: second update dropped, status 3 until dmireset
        do_upd(2'd1, 7'h05, 32'h0, 0);
        do_upd(2'd2, 7'h06, 32'h1, 0);
        do_cap(0);
        check_eq("plan_busy_st", dmi_pdo[1:0], 2'd3);
        do_ack(0, 0, 32'hA5A5_0001, 0);
        do_dmireset();
        do_upd(2'd2, 7'h07, 32'hCAFEF00D, 0);
        do_ack(1, 0, $urandom, 0);
        do_cap(0);
        check_eq("plan_busy_ok", dmi_pdo[1:0], 2'd0);

        // bus error: sticky 2, later update ignored, dmireset clears
        do_upd(2'd1, 7'h30, 32'h0, 0);
        do_ack(1, 1, 32'h0BAD_0BAD, 0);
        do_cap(0);
        check_eq("plan_err_st", dmi_pdo[1:0], 2'd2);
        do_upd(2'd2, 7'h31, 32'h1234, 0);
        check_eq("plan_err_noreq", dm_req, 0);
        do_cap(1);
        do_cap(0);
        check_eq("plan_err_clr", dmi_pdo[1:0], 2'd0);

        // capture on the completing edge, and dmireset together with an update
        do_upd(2'd1, 7'h44, 32'h0, 0);
        do_ack(0, 1, 32'h7777_8888, 1);
        do_upd(2'd2, 7'h45, 32'h55AA, 1);
        do_ack(0, 0, $urandom, 0);

`ifdef DP_DMI_TIMEOUT_EN
        do_upd(2'd1, 7'h50, 32'h0, 0);
        hi_cnt = 0;
        while (dm_req && hi_cnt < 100) begin
            hi_cnt++;
            tick();
        end
        check_eq("tmo_cycles", hi_cnt, TMO);
        m_busy = 0; m_sticky = 2'd2;
        do_cap(0);
        check_eq("tmo_status", dmi_pdo[1:0], 2'd2);
        do_dmireset();
`else
        do_upd(2'd1, 7'h50, 32'h0, 0);
        hi_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (dm_req) hi_cnt++;
            tick();
        end
        check_eq("no_tmo_held", hi_cnt, 1000);
        do_ack(0, 0, 32'h1357_9BDF, 0);
`endif

        // random traffic
        for (int it = 0; it < 150; it++) begin
            act = $urandom_range(0, 5);
            case (act)
                0, 1: begin
                    r_op  = 2'($urandom_range(0, 3));
                    r_a   = 7'($urandom);
                    r_clr = !m_busy && ($urandom_range(0, 3) == 0);
                    do_upd(r_op, r_a, $urandom, r_clr);
                end
                2: do_cap(!m_busy && ($urandom_range(0, 3) == 0));
                3: do_dmireset();
                default: begin
                    if (m_busy) do_ack($urandom_range(0, 3), $urandom_range(0, 3) == 0,
                                       $urandom, $urandom_range(0, 3) == 0);
                    else idle_step();
                end
            endcase
        end
        if (m_busy) do_ack(0, 0, $urandom, 0);
        do_dmireset();

        // asynchronous reset with a request in flight
        do_cap(0);
        do_upd(2'd1, 7'h2A, 32'h0, 0);
        check_eq("mid_req_up", dm_req, 1);
        #2 iresetn = 1'b0;
        #1;
        check_eq("mid_rst_req", dm_req, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_pdo", dmi_pdo, 0);
        model_reset();
        @(negedge iclk);
        iresetn = 1'b1;
        idle_step();
        do_cap(0);
        check_eq("post_rst_pdo", dmi_pdo, 0);
        idle_step();
        check_eq("exp_q_empty", exp_q.size(), 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_dmi_ctrl.md
# dp_dmi_ctrl

Debug module interface (DMI) request controller.
- Sits directly downstream of the DAP's DMI boundary-scan register.
- Takes each DMI update (address, data, opcode) shifted in over JTAG and runs one read or write on the debug-module bus using a req/ack handshake.
- Tracks a sticky DMI status.
- Presents {address, read data, status} for the next Capture-DR of the DMI register.

## Interface
Parameters:
- ABITS, 7, DMI address width.
- TMO_CYCLES, 255, bus-timeout limit in iclk cycles (used only when DP_DMI_TIMEOUT_EN is defined); minimum 1.

Ports:
- iclk  in  1  internal clock (TAP-derived clock). One clock only.
- iresetn  in  1  internal reset; asynchronous, active-low.
- upd_dmi  in  1  one-cycle pulse: Update-DR with DMI selected.
- cap_dmi  in  1  one-cycle pulse: Capture-DR with DMI selected.
- dmi_pdi  in  ABITS+34  shifted value {addr[ABITS+33:34], data[33:2], op[1:0]}.
- dmi_pdo  out  ABITS+34  capture value {addr, rdata, status[1:0]}.
- dmireset  in  1  pulse from the DTMCS write; clears sticky status.
- dm_req  out  1  bus request.
- dm_we  out  1  1 = write, 0 = read.
- dm_addr  out  ABITS  bus address.
- dm_wdata  out  32  write data.
- dm_ack  in  1  bus acknowledge; sampled while dm_req = 1.
- dm_rdata  in  32  read data; valid when dm_ack = 1.
- dm_err  in  1  bus error; qualified by dm_ack.
- busy  out  1  transaction in flight.

## Operation
- Opcodes in op:
  - 0 = nop: no bus access, status unchanged.
  - 1 = read.
  - 2 = write.
  - 3 = reserved: treated as nop.
- Status codes: 0 = success, 2 = failed, 3 = busy. Status is sticky: once nonzero it holds until dmireset.
- FSM has two states:
  - IDLE → REQ on upd_dmi, op ∈ {1,2}, sticky = 0. On entry: latch addr and data into dm_addr/dm_wdata, set dm_we = (op == 2).
  - REQ → IDLE on dm_req & dm_ack. On this edge, rdata ← dm_rdata (reads only; writes leave rdata unchanged), and if dm_err = 1 then sticky ← 2.
- upd_dmi while in REQ: request dropped, sticky ← 3.
- upd_dmi while sticky ≠ 0: request dropped, no bus access, status unchanged.
- cap_dmi:
  - dmi_pdo ← {last accepted addr, rdata, sticky}.
  - If in REQ at capture: the status field reads 3 and sticky ← 3.
- dmireset: sticky ← 0.
  - Simultaneous dmireset and upd_dmi: clear is applied first, and the request is evaluated against sticky = 0.
  - Simultaneous dmireset and cap_dmi: capture reports the pre-clear status.
- Reset mid-transaction: return to IDLE immediately and drop dm_req. No completion is reported.

## Timing
- Reset values: dm_req, dm_we, dm_addr, dm_wdata, busy, dmi_pdo, rdata, sticky = 0; state = IDLE.
- dm_req, dm_we, dm_addr, dm_wdata are registered. dm_req rises the cycle after the accepting upd_dmi.
- dm_addr, dm_wdata, dm_we stay stable while dm_req = 1. dm_req falls the cycle after the ack edge.
- Minimum transaction is 1 cycle of dm_req (ack already high). busy = (state == REQ).
- dmi_pdo updates only on the edge where cap_dmi = 1 and holds otherwise.
- Completion and cap_dmi on the same edge: the capture sees the completed values (rdata and status from this ack), and the status is not forced to 3.

## Configuration
- DP_DMI_TIMEOUT_EN defined:
  - An 8+ bit counter, sized to TMO_CYCLES, counts cycles in REQ.
  - When count == TMO_CYCLES with no ack: drop dm_req, go to IDLE, sticky ← 2.
  - Counter clears on entry to REQ.
  - Ack on the expiry cycle counts as a normal completion.
- Undefined: no counter. REQ waits indefinitely for dm_ack.

## Test plan
- Write: upd op=2, addr=0x10, data=0xDEADBEEF; ack after 3 cycles → dm_req high 3 cycles with dm_we=1, addr 0x10, wdata 0xDEADBEEF; following cap → status 0.
- Read: upd op=1, addr=0x11; ack with rdata 0x12345678 → cap gives {0x11, 0x12345678, 0}.
- Busy: upd read, hold ack low, upd again → second request ignored; cap → status 3; dmireset then new upd → accepted, status 0 after ack.
- Bus error: read acked with dm_err=1 → status 2 sticky; next upd write → no dm_req; dmireset clears status.
- Timeout (DP_DMI_TIMEOUT_EN, TMO_CYCLES=4): never ack → dm_req drops after exactly 4 cycles, status 2. Without the macro, dm_req stays high for 1000 cycles.
- Reset mid-REQ: assert iresetn=0 with dm_req=1 → dm_req, busy, dmi_pdo = 0 immediately (asynchronous).
